lcd_line_arbiter: RTL and testbench

LCD_LINE_ARBITER -- requirements
Module: lcd_line_arbiter

---
 rtl/lcd_line_arbiter.sv | 147 ++++++++++++++
 tb/tb_lcd_line_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_line_arbiter.sv
// lcd_line_arbiter: grants one of two requesters the LCD driver and writes
// that requester's 16-character line. The line is written as a DDRAM address
// command followed by 16 data bytes.
// Build option LCD_ARB_FIXED_PRIO_EN: when defined, Req0 always wins a tie.
// When undefined, ties are resolved round-robin.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for driver Ready and a request
// POS_REQ | address command presented, waiting for Busy to rise
// POS_ACK | address command accepted, waiting for Busy to fall
// POS_RDY | bus released, waiting for driver Ready
// CHR_REQ | character byte presented, waiting for Busy to rise
// CHR_ACK | character byte accepted, waiting for Busy to fall
// CHR_RDY | bus released; on Ready either advance or finish the line
// DONE    | one-cycle completion pulse, grant released
module lcd_line_arbiter (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         Req0,
   input  logic         Req1,
   input  logic [128:1] Line0,
   input  logic [128:1] Line1,
   input  logic         Row0,
   input  logic         Row1,
   output logic         Gnt0,
   output logic         Gnt1,
   output logic         Done0,
   output logic         Done1,
   output logic [7:0]   DataValue,
   output logic         Command,
   output logic         Write,
   input  logic         Busy,
   input  logic         Ready
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] POS_REQ = 3'd1;
   localparam logic [2:0] POS_ACK = 3'd2;
   localparam logic [2:0] POS_RDY = 3'd3;
   localparam logic [2:0] CHR_REQ = 3'd4;
   localparam logic [2:0] CHR_ACK = 3'd5;
   localparam logic [2:0] CHR_RDY = 3'd6;
   localparam logic [2:0] DONE    = 3'd7;

   logic [2:0]   state;
   logic [3:0]   char_cnt;
   logic [127:0] shift_reg;
   logic         row;
   logic         pick1;

`ifdef LCD_ARB_FIXED_PRIO_EN
   // Fixed priority: requester 1 is chosen only when requester 0 is not asking.
   always_comb begin
      pick1 = ~Req0;
   end
`else
   logic last_gnt;

   // Round-robin: on a tie, serve the requester that was not served last.
   always_comb begin
      pick1 = Req1 & (~Req0 | ~last_gnt);
   end

   // Remember the most recent winner so that ties alternate between requesters.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         last_gnt <= 1'b1;
      end else if (state == IDLE && Ready && (Req0 | Req1)) begin
         last_gnt <= pick1;
      end
   end
`endif

   // Sequencer: arbitration, latching of the line, and the driver handshake per byte.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state     <= IDLE;
         Gnt0      <= 1'b0;
         Gnt1      <= 1'b0;
         char_cnt  <= 4'd0;
         shift_reg <= '0;
         row       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (Ready && (Req0 | Req1)) begin
                  shift_reg <= pick1 ? Line1 : Line0;
                  row       <= pick1 ? Row1 : Row0;
                  Gnt0      <= ~pick1;
                  Gnt1      <= pick1;
                  char_cnt  <= 4'd0;
                  state     <= POS_REQ;
               end
            end
            POS_REQ: if (Busy)  state <= POS_ACK;
            POS_ACK: if (!Busy) state <= POS_RDY;
            POS_RDY: if (Ready) state <= CHR_REQ;
            CHR_REQ: if (Busy)  state <= CHR_ACK;
            CHR_ACK: if (!Busy) state <= CHR_RDY;
            CHR_RDY: begin
               if (Ready) begin
                  if (char_cnt == 4'd15) begin
                     state <= DONE;
                  end else begin
                     char_cnt  <= char_cnt + 4'd1;
                     shift_reg <= {shift_reg[119:0], 8'h00};
                     state     <= CHR_REQ;
                  end
               end
            end
            DONE: begin
               Gnt0  <= 1'b0;
               Gnt1  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Driver bus: the bus stays all-zero unless a write is presented.
   always_comb begin
      Write     = 1'b0;
      Command   = 1'b0;
      DataValue = 8'h00;
      case (state)
         POS_REQ, POS_ACK: begin
            Write     = 1'b1;
            Command   = 1'b1;
            DataValue = row ? 8'hC0 : 8'h80;
         end
         CHR_REQ, CHR_ACK: begin
            Write     = 1'b1;
            DataValue = shift_reg[127:120];
         end
         default: ;
      endcase
   end

   // Completion pulse goes to whichever requester holds the grant.
   always_comb begin
      Done0 = (state == DONE) && Gnt0;
      Done1 = (state == DONE) && Gnt1;
   end

endmodule

// File: tb/tb_lcd_line_arbiter.sv
// Directed bench for lcd_line_arbiter, with a simple Busy/Ready driver responder.
module tb_lcd_line_arbiter;

   logic         Clk = 1'b0;
   logic         Rst = 1'b1;
   logic         Req0 = 1'b0, Req1 = 1'b0, Row0 = 1'b0, Row1 = 1'b0;
   logic         Busy = 1'b0, Ready = 1'b0;
   logic [128:1] Line0 = '0, Line1 = '0;
   logic         Gnt0, Gnt1, Done0, Done1, Command, Write;
   logic [7:0]   DataValue;

   int checks = 0;
   int failures = 0;
   int done0_cnt = 0;
   int done1_cnt = 0;
   int drv_bcnt = 0;
   logic drv_wait_fall = 1'b0;
   logic pg0 = 1'b0, pg1 = 1'b0;
   logic [8:0] drv_log[$];
   int gnt_order[$];
   int viol;
   int n;

   logic [7:0] hello_exp [16] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h57, 8'h4F,
                                  8'h52, 8'h4C, 8'h44, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};

   lcd_line_arbiter dut (
      .Clk(Clk), .Rst(Rst), .Req0(Req0), .Req1(Req1), .Line0(Line0), .Line1(Line1),
      .Row0(Row0), .Row1(Row1), .Gnt0(Gnt0), .Gnt1(Gnt1), .Done0(Done0), .Done1(Done1),
      .DataValue(DataValue), .Command(Command), .Write(Write), .Busy(Busy), .Ready(Ready)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input string tag);
      int k;
      k = 0;
      do begin
         @(negedge Clk);
         k++;
      end while (!(Done0 || Done1) && k < 3000);
      chk({tag, "_done_seen"}, 32'(Done0 || Done1), 1);
   endtask

   task automatic do_reset();
      Rst = 1'b1;
      Req0 = 1'b0;
      Req1 = 1'b0;
      repeat (2) @(negedge Clk);
      Rst = 1'b0;
      repeat (4) @(negedge Clk);
      drv_log.delete();
      gnt_order.delete();
      done0_cnt = 0;
      done1_cnt = 0;
   endtask

   // Driver responder: logs each presented byte, then holds Busy for two cycles.
   initial begin
      forever begin
         @(negedge Clk);
         if (Busy) begin
            drv_bcnt--;
            if (drv_bcnt == 0) begin
               Busy = 1'b0;
               drv_wait_fall = 1'b1;
            end
         end else if (drv_wait_fall) begin
            if (!Write) drv_wait_fall = 1'b0;
         end else if (Write) begin
            drv_log.push_back({Command, DataValue});
            Busy = 1'b1;
            drv_bcnt = 2;
         end
      end
   end

   // Continuous properties plus counting of Done pulses and the order of grants.
   initial begin
      forever begin
         @(negedge Clk);
         if (!Rst) begin
            chk("gnt_exclusive", 32'(Gnt0 & Gnt1), 0);
            chk("quiet_bus", 32'(!Write && (DataValue != 8'h00 || Command)), 0);
         end
         if (Done0) done0_cnt++;
         if (Done1) done1_cnt++;
         if (Gnt0 && !pg0) gnt_order.push_back(0);
         if (Gnt1 && !pg1) gnt_order.push_back(1);
         pg0 = Gnt0;
         pg1 = Gnt1;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      Ready = 1'b1;
      repeat (2) @(negedge Clk);
      chk("rst_gnt0", 32'(Gnt0), 0);
      chk("rst_gnt1", 32'(Gnt1), 0);
      chk("rst_done", 32'(Done0 | Done1), 0);
      chk("rst_write", 32'(Write), 0);
      chk("rst_cmd", 32'(Command), 0);
      chk("rst_data", 32'(DataValue), 0);
      do_reset();

      // single line "HELLO WORLD     " on the top row
      Line0 = "HELLO WORLD     ";
      Row0 = 1'b0;
      Req0 = 1'b1;
      @(negedge Clk);
      chk("hello_gnt0", 32'(Gnt0), 1);
      chk("hello_gnt1", 32'(Gnt1), 0);
      wait_done("hello");
      chk("hello_done0_pulse", 32'(Done0), 1);
      Req0 = 1'b0;
      repeat (3) @(negedge Clk);
      chk("hello_gnt0_released", 32'(Gnt0), 0);
      chk("hello_done0_count", done0_cnt, 1);
      chk("hello_done1_count", done1_cnt, 0);
      chk("hello_len", drv_log.size(), 17);
      chk("hello_addr", 32'(drv_log[0]), 32'h180);
      for (int i = 0; i < 16; i++) chk("hello_char", 32'(drv_log[i+1]), 32'({1'b0, hello_exp[i]}));

      // simultaneous requests after reset: requester 0 first, then 1 on the bottom row
      do_reset();
      Line0 = "0123456789ABCDEF";
      Line1 = "abcdefghijklmnop";
      Row0 = 1'b0;
      Row1 = 1'b1;
      Req0 = 1'b1;
      Req1 = 1'b1;
      @(negedge Clk);
      chk("tie_gnt0", 32'(Gnt0), 1);
      chk("tie_gnt1", 32'(Gnt1), 0);
      Req0 = 1'b0;
      wait_done("tie_first");
      chk("tie_first_done0", 32'(Done0), 1);
      wait_done("tie_second");
      chk("tie_second_done1", 32'(Done1), 1);
      Req1 = 1'b0;
      repeat (3) @(negedge Clk);
      chk("tie_len", drv_log.size(), 34);
      chk("tie_addr0", 32'(drv_log[0]), 32'h180);
      chk("tie_first_char0", 32'(drv_log[1]), 32'h030);
      chk("tie_last_char0", 32'(drv_log[16]), 32'h046);
      chk("tie_addr1", 32'(drv_log[17]), 32'h1C0);
      chk("tie_first_char1", 32'(drv_log[18]), 32'h061);
      chk("tie_last_char1", 32'(drv_log[33]), 32'h070);
      chk("tie_done_counts", 32'({done0_cnt[7:0], done1_cnt[7:0]}), 32'h0101);

      // both requests held: grant sequence
      do_reset();
      Req0 = 1'b1;
      Req1 = 1'b1;
      for (int k = 0; k < 4; k++) wait_done("held");
      Req0 = 1'b0;
      Req1 = 1'b0;
      repeat (3) @(negedge Clk);
      chk("held_grants", gnt_order.size(), 4);
`ifdef LCD_ARB_FIXED_PRIO_EN
      for (int k = 0; k < 4; k++) chk("held_order", gnt_order[k], 0);
`else
      for (int k = 0; k < 4; k++) chk("held_order", gnt_order[k], k % 2);
`endif

      // driver not ready: request must wait
      do_reset();
      Ready = 1'b0;
      Row1 = 1'b1;
      Req1 = 1'b1;
      viol = 0;
      repeat (50) begin
         @(negedge Clk);
         if (Gnt1 || Gnt0 || Write) viol++;
      end
      chk("notready_quiet", viol, 0);
      Ready = 1'b1;
      @(negedge Clk);
      chk("notready_gnt1", 32'(Gnt1), 1);
      Req1 = 1'b0;
      wait_done("notready");
      chk("notready_done1", 32'(Done1), 1);
      repeat (3) @(negedge Clk);

      // reset during the 7th character
      do_reset();
      Line0 = "HELLO WORLD     ";
      Row0 = 1'b0;
      Req0 = 1'b1;
      @(negedge Clk);
      chk("abort_gnt0", 32'(Gnt0), 1);
      Req0 = 1'b0;
      n = 0;
      do begin
         @(negedge Clk);
         n++;
      end while (!(drv_log.size() >= 8 && Write) && n < 2000);
      chk("abort_reached_char7", 32'(drv_log.size() >= 8 && Write), 1);
      chk("abort_char7_value", 32'(drv_log[7]), 32'h057);
      Rst = 1'b1;
      @(negedge Clk);
      chk("abort_write_dropped", 32'(Write), 0);
      chk("abort_gnt_dropped", 32'(Gnt0), 0);
      Rst = 1'b0;
      repeat (12) @(negedge Clk);
      chk("abort_no_done", done0_cnt, 0);
      drv_log.delete();
      Req0 = 1'b1;
      @(negedge Clk);
      chk("restart_gnt0", 32'(Gnt0), 1);
      Req0 = 1'b0;
      wait_done("restart");
      repeat (3) @(negedge Clk);
      chk("restart_len", drv_log.size(), 17);
      chk("restart_addr", 32'(drv_log[0]), 32'h180);
      chk("restart_char0", 32'(drv_log[1]), 32'h048);

      // line, row and request changed mid-service
      do_reset();
      Line0 = "ABCDEFGHIJKLMNOP";
      Row0 = 1'b0;
      Req0 = 1'b1;
      @(negedge Clk);
      chk("latch_gnt0", 32'(Gnt0), 1);
      Line0 = "zzzzzzzzzzzzzzzz";
      Row0 = 1'b1;
      Req0 = 1'b0;
      wait_done("latch");
      chk("latch_done0", 32'(Done0), 1);
      repeat (3) @(negedge Clk);
      chk("latch_done0_count", done0_cnt, 1);
      chk("latch_len", drv_log.size(), 17);
      chk("latch_addr", 32'(drv_log[0]), 32'h180);
      for (int i = 0; i < 16; i++) chk("latch_char", 32'(drv_log[i+1]), 32'(8'(8'h41 + i)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
